// File: rtl/pctrl_mc.sv
// pctrl_mc - multi-channel proportional controller.
//
// For every channel i it computes out_i = min((k * |g_i - m_i|) >> FRAC, 2^W-1).
// It forces out_i = 0 and dir_i = 0 when g_i == 0.
// A single multiplier is shared by all channels through a two-stage pipeline:
//   stage 1 : absolute error, direction and zero-setpoint flag
//   stage 2 : multiply, scale, saturate
// Results collect in working registers. All channels are copied to the
// outputs together in the cycle that pulses done.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request a computation (ignored while busy)
//   k         shared unsigned gain
//   g_flat    setpoints, channel i at [i*W +: W]
//   m_flat    measurements, same packing
//   busy      computation in progress
//   done      one-cycle pulse when out_flat/dir_flat were updated
//   out_flat  control magnitudes, same packing
//   dir_flat  bit i set when g_i > m_i
module pctrl_mc #(
  parameter int W    = 8,
  parameter int FRAC = 8,
  parameter int CH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    k,
  input  logic [CH*W-1:0] g_flat,
  input  logic [CH*W-1:0] m_flat,
  output logic            busy,
  output logic            done,
  output logic [CH*W-1:0] out_flat,
  output logic [CH-1:0]   dir_flat
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_reg, state_next;
  logic   snap, issue, commit;

  // Snapshot of the operands taken when start is accepted
  logic [W-1:0]    k_reg;
  logic [CH*W-1:0] g_snap_reg, m_snap_reg;
  logic [IW-1:0]   idx_reg;

  // Stage-1 pipeline registers
  logic            s1_valid_reg;
  logic [IW-1:0]   s1_ch_reg;
  logic [W-1:0]    s1_e_reg;
  logic            s1_d_reg, s1_z_reg;

  // Working results, and a flag set once the last channel has been written
  logic [W-1:0]    work_mag_reg [CH];
  logic [CH-1:0]   work_dir_reg;
  logic [CH*W-1:0] work_flat;
  logic            wlast_reg;

  logic            busy_reg, done_reg;
  logic [CH*W-1:0] out_reg;
  logic [CH-1:0]   dir_reg;

  logic [W-1:0] g_arr [CH];
  logic [W-1:0] m_arr [CH];

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_unpack
      assign g_arr[gi] = g_snap_reg[gi*W +: W];
      assign m_arr[gi] = m_snap_reg[gi*W +: W];
      assign work_flat[gi*W +: W] = work_mag_reg[gi];
    end
  endgenerate

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    snap       = 1'b0;
    issue      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          snap       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        // The last channel lands in the working registers one edge before commit
        if (wlast_reg) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- stage 1 (combinational part) ----------------
  logic [W-1:0] g_sel, m_sel, e_next;
  logic         d_next, z_next;

  always_comb begin
    g_sel  = g_arr[idx_reg];
    m_sel  = m_arr[idx_reg];
    d_next = (g_sel > m_sel);
    z_next = (g_sel == '0);
    e_next = d_next ? (g_sel - m_sel) : (m_sel - g_sel);
  end

  // ---------------- stage 2 (combinational part) ----------------
  logic [2*W-1:0] prod, q;
  logic [W-1:0]   res_mag;
  logic           res_dir;

  always_comb begin
    prod = {{W{1'b0}}, k_reg} * {{W{1'b0}}, s1_e_reg};
    q    = prod >> FRAC;
    if (s1_z_reg)             res_mag = '0;
    else if (|q[2*W-1:W])     res_mag = '1;  // scaled product does not fit in W bits
    else                      res_mag = q[W-1:0];
    res_dir = s1_d_reg & ~s1_z_reg;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg        <= '0;
      g_snap_reg   <= '0;
      m_snap_reg   <= '0;
      idx_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_ch_reg    <= '0;
      s1_e_reg     <= '0;
      s1_d_reg     <= 1'b0;
      s1_z_reg     <= 1'b0;
      for (int i = 0; i < CH; i++) work_mag_reg[i] <= '0;
      work_dir_reg <= '0;
      wlast_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      out_reg      <= '0;
      dir_reg      <= '0;
    end else begin
      done_reg     <= commit;
      s1_valid_reg <= issue;

      if (snap) begin
        k_reg      <= k;
        g_snap_reg <= g_flat;
        m_snap_reg <= m_flat;
        idx_reg    <= '0;
        busy_reg   <= 1'b1;
      end

      if (issue) begin
        s1_ch_reg <= idx_reg;
        s1_e_reg  <= e_next;
        s1_d_reg  <= d_next;
        s1_z_reg  <= z_next;
        if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
      end

      if (s1_valid_reg) begin
        work_mag_reg[s1_ch_reg] <= res_mag;
        work_dir_reg[s1_ch_reg] <= res_dir;
        if (s1_ch_reg == LAST_IDX) wlast_reg <= 1'b1;
      end

      if (commit) begin
        out_reg   <= work_flat;
        dir_reg   <= work_dir_reg;
        busy_reg  <= 1'b0;
        wlast_reg <= 1'b0;
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign out_flat = out_reg;
  assign dir_flat = dir_reg;

endmodule

// File: tb/tb_pctrl_mc.sv
module tb_pctrl_mc;

  typedef struct packed {
    logic [63:0] out;
    logic [7:0]  dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u0: W=8 FRAC=8 CH=4
  logic        start0, busy0, done0;
  logic [7:0]  k0;
  logic [31:0] g0, m0, out0;
  logic [3:0]  dir0;
  // u1: W=8 FRAC=4 CH=1
  logic        start1, busy1, done1;
  logic [7:0]  k1, g1, m1, out1;
  logic [0:0]  dir1;
  // u2: W=8 FRAC=4 CH=7
  logic        start2, busy2, done2;
  logic [7:0]  k2;
  logic [55:0] g2, m2, out2;
  logic [6:0]  dir2;

  pctrl_mc #(.W(8), .FRAC(8), .CH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .k(k0), .g_flat(g0), .m_flat(m0),
    .busy(busy0), .done(done0), .out_flat(out0), .dir_flat(dir0));
  pctrl_mc #(.W(8), .FRAC(4), .CH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .k(k1), .g_flat(g1), .m_flat(m1),
    .busy(busy1), .done(done1), .out_flat(out1), .dir_flat(dir1));
  pctrl_mc #(.W(8), .FRAC(4), .CH(7)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .k(k2), .g_flat(g2), .m_flat(m2),
    .busy(busy2), .done(done2), .out_flat(out2), .dir_flat(dir2));

  int checks_cnt = 0;
  int errors_cnt = 0;
  exp_t exp_q0[$], exp_q1[$], exp_q2[$];
  int push0 = 0, push1 = 0, push2 = 0;
  int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: min((k*|g-m|) >> frac, 255), forced to 0 with dir 0 when g == 0
  function automatic exp_t model(input int kk, input logic [63:0] gf, input logic [63:0] mf,
                                 input int ch, input int frac);
    exp_t r;
    r = '0;
    for (int i = 0; i < ch; i++) begin
      int gv, mv, e, q;
      logic dv;
      gv = int'(gf[i*8 +: 8]);
      mv = int'(mf[i*8 +: 8]);
      e  = (gv > mv) ? gv - mv : mv - gv;
      q  = (kk * e) >>> frac;
      if (q > 255) q = 255;
      dv = (gv > mv);
      if (gv == 0) begin
        q  = 0;
        dv = 1'b0;
      end
      r.out[i*8 +: 8] = q[7:0];
      r.dir[i]        = dv;
    end
    return r;
  endfunction

  // Scoreboard monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n && done0) begin
      exp_t e;
      done_cnt0++;
      check_val("u0_sb_empty_on_done", 64'(exp_q0.size() == 0), 64'd0);
      check_val("u0_busy_in_done", 64'(busy0), 64'd0);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check_val("u0_out", 64'(out0), e.out);
        check_val("u0_dir", 64'(dir0), 64'(e.dir));
        $display("txn u0 out=%h dir=%b", out0, dir0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      exp_t e;
      done_cnt1++;
      check_val("u1_sb_empty_on_done", 64'(exp_q1.size() == 0), 64'd0);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check_val("u1_out", 64'(out1), e.out);
        check_val("u1_dir", 64'(dir1), 64'(e.dir));
        $display("txn u1 k=%0d g=%0d m=%0d out=%0d dir=%b", k1, g1, m1, out1, dir1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      exp_t e;
      done_cnt2++;
      check_val("u2_sb_empty_on_done", 64'(exp_q2.size() == 0), 64'd0);
      if (exp_q2.size() != 0) begin
        e = exp_q2.pop_front();
        check_val("u2_out", 64'(out2), e.out);
        check_val("u2_dir", 64'(dir2), 64'(e.dir));
        $display("txn u2 k=%0d out=%h dir=%b", k2, out2, dir2);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each run task returns just after the edge that raises done
  task automatic run0(input logic [7:0] kk, input logic [31:0] gg, input logic [31:0] mm);
    k0 = kk; g0 = gg; m0 = mm; start0 = 1'b1;
    exp_q0.push_back(model(kk, {32'b0, gg}, {32'b0, mm}, 4, 8));
    push0++;
    cyc();
    start0 = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic run1(input logic [7:0] kk, input logic [7:0] gg, input logic [7:0] mm);
    k1 = kk; g1 = gg; m1 = mm; start1 = 1'b1;
    exp_q1.push_back(model(kk, {56'b0, gg}, {56'b0, mm}, 1, 4));
    push1++;
    cyc();
    start1 = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic run2(input logic [7:0] kk, input logic [55:0] gg, input logic [55:0] mm);
    k2 = kk; g2 = gg; m2 = mm; start2 = 1'b1;
    exp_q2.push_back(model(kk, {8'b0, gg}, {8'b0, mm}, 7, 4));
    push2++;
    cyc();
    start2 = 1'b0;
    repeat (9) cyc();
  endtask

  function automatic logic [7:0] rnd_g();
    return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
  endfunction

  initial begin
    exp_t first_exp;
    int   dc;
    rst_n = 1'b0;
    start0 = 0; start1 = 0; start2 = 0;
    k0 = 0; g0 = 0; m0 = 0; k1 = 0; g1 = 0; m1 = 0; k2 = 0; g2 = 0; m2 = 0;
    repeat (3) cyc();
    check_val("rst_out", 64'(out0), 64'd0);
    check_val("rst_dir", 64'(dir0), 64'd0);
    check_val("rst_busy", 64'(busy0), 64'd0);
    check_val("rst_done", 64'(done0), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Directed: timing of busy/done and the documented example
    k0 = 8'd128; g0 = {8'd100, 8'd0, 8'd50, 8'd200}; m0 = {8'd100, 8'd30, 8'd150, 8'd100};
    start0 = 1'b1;
    exp_q0.push_back(model(128, {32'b0, g0}, {32'b0, m0}, 4, 8));
    push0++;
    cyc();
    start0 = 1'b0;
    check_val("A_busy_e0", 64'(busy0), 64'd1);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      check_val("A_busy", 64'(busy0), 64'd1);
      check_val("A_done_early", 64'(done0), 64'd0);
    end
    cyc();
    check_val("A_done", 64'(done0), 64'd1);
    check_val("A_busy_at_done", 64'(busy0), 64'd0);
    check_val("A_out_const", 64'(out0), 64'h0000_3232);
    check_val("A_dir_const", 64'(dir0), 64'b0001);
    cyc();
    check_val("A_done_pulse", 64'(done0), 64'd0);
    check_val("A_out_hold", 64'(out0), 64'h0000_3232);

    // Largest gain / error without saturation, and zero gain
    run0(8'd255, {8'd0, 8'd0, 8'd0, 8'd255}, 32'd0);
    check_val("B_out0", 64'(out0[7:0]), 64'd254);
    check_val("B_dir0", 64'(dir0[0]), 64'd1);
    run0(8'd0, {8'd9, 8'd200, 8'd3, 8'd77}, {8'd250, 8'd1, 8'd90, 8'd7});
    check_val("B_k0_out", 64'(out0), 64'd0);

    // FRAC=4 instance: saturation and a small exact case
    run1(8'd255, 8'd255, 8'd0);
    check_val("C_sat", 64'(out1), 64'd255);
    check_val("C_sat_dir", 64'(dir1), 64'd1);
    run1(8'd16, 8'd10, 8'd4);
    check_val("C_small", 64'(out1), 64'd6);
    check_val("C_small_dir", 64'(dir1), 64'd1);

    // start ignored while busy; inputs changed after the snapshot
    cyc();
    dc = done_cnt0;
    k0 = 8'd200; g0 = {8'd10, 8'd20, 8'd30, 8'd240}; m0 = {8'd5, 8'd60, 8'd30, 8'd16};
    start0 = 1'b1;
    exp_q0.push_back(model(200, {32'b0, g0}, {32'b0, m0}, 4, 8));
    push0++;
    cyc();
    start0 = 1'b0;
    k0 = 8'd1; g0 = 32'hFFFF_FFFF; m0 = 32'd0;
    cyc();
    start0 = 1'b1;
    repeat (3) cyc();
    start0 = 1'b0;
    repeat (12) cyc();
    check_val("D_single_done", 64'(done_cnt0 - dc), 64'd1);

    // Back-to-back: start sampled in the done cycle
    run0(8'd128, {8'd100, 8'd0, 8'd50, 8'd200}, {8'd100, 8'd30, 8'd150, 8'd100});
    first_exp = model(128, {32'h0, 8'd100, 8'd0, 8'd50, 8'd200}, {32'h0, 8'd100, 8'd30, 8'd150, 8'd100}, 4, 8);
    k0 = 8'd90; g0 = {8'd1, 8'd2, 8'd250, 8'd40}; m0 = {8'd0, 8'd200, 8'd10, 8'd41};
    start0 = 1'b1;
    exp_q0.push_back(model(90, {32'b0, g0}, {32'b0, m0}, 4, 8));
    push0++;
    cyc();
    start0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      check_val("E_hold_out", 64'(out0), first_exp.out);
    end
    cyc();
    check_val("E_second_done", 64'(done0), 64'd1);

    // Reset during a computation
    cyc();
    dc = done_cnt0;
    k0 = 8'd77; g0 = {8'd9, 8'd99, 8'd199, 8'd250}; m0 = 32'd0;
    start0 = 1'b1;
    exp_q0.push_back(model(77, {32'b0, g0}, {32'b0, m0}, 4, 8));
    cyc();
    start0 = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    void'(exp_q0.pop_back());
    check_val("F_rst_out", 64'(out0), 64'd0);
    check_val("F_rst_dir", 64'(dir0), 64'd0);
    check_val("F_rst_busy", 64'(busy0), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    check_val("F_no_done", 64'(done_cnt0 - dc), 64'd0);
    run0(8'd77, {8'd9, 8'd99, 8'd199, 8'd250}, 32'd0);
    check_val("F_after_rst_done", 64'(done0), 64'd1);

    // Random runs against the reference model
    for (int n = 0; n < 500; n++)
      run1(8'($urandom_range(0, 255)), rnd_g(), 8'($urandom_range(0, 255)));
    for (int n = 0; n < 500; n++) begin
      logic [55:0] gg, mm;
      for (int c = 0; c < 7; c++) begin
        gg[c*8 +: 8] = rnd_g();
        mm[c*8 +: 8] = 8'($urandom_range(0, 255));
      end
      run2(8'($urandom_range(0, 255)), gg, mm);
    end

    repeat (3) cyc();
    check_val("end_q0_empty", 64'(exp_q0.size()), 64'd0);
    check_val("end_q1_empty", 64'(exp_q1.size()), 64'd0);
    check_val("end_q2_empty", 64'(exp_q2.size()), 64'd0);
    check_val("end_dones0", 64'(done_cnt0), 64'(push0));
    check_val("end_dones1", 64'(done_cnt1), 64'(push1));
    check_val("end_dones2", 64'(done_cnt2), 64'(push2));

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
